// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder slice.
package dmem_pkg;
    localparam int ADDR_W  = 30;
    localparam int DATA_W  = 32;
    localparam int LAT_MAX = 4;

    localparam logic DRW_READ  = 1'b0;
    localparam logic DRW_WRITE = 1'b1;

    function automatic logic in_range(
        input logic [ADDR_W-1:0] addr,
        input logic [ADDR_W-1:0] base,
        input int                aw
    );
        return (addr >> aw) == (base >> aw);
    endfunction
endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM, registered read, no reset (block-RAM inferable).
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic              CLK,
    input  logic              WE,
    input  logic [AW-1:0]     ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA
);
    logic [DATA_W-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (WE)
            mem[ADDR] <= WDATA;
        RDATA <= mem[ADDR];
    end
endmodule

// File: rtl/dmem_responder.sv
// Target side of the core D-port: RAM, read latency pipeline,
// sticky out-of-range record and saturating access counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int              AW        = 10,
    parameter logic [ADDR_W-1:0] BASE_WORD = '0,
    parameter int              LAT       = 1,
    parameter int              CW        = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              DREQ,
    input  logic              DRW,
    input  logic [ADDR_W-1:0] DADDR,
    input  logic [DATA_W-1:0] DWDATA,
    output logic [DATA_W-1:0] DRDATA,
    output logic              RVALID,
    output logic              ERR,
    output logic [ADDR_W-1:0] ERR_ADDR,
    output logic              ERR_RW,
    output logic [CW-1:0]     RD_CNT,
    output logic [CW-1:0]     WR_CNT
);
    if (LAT < 1 || LAT > LAT_MAX) begin : g_bad_lat
        $error("dmem_responder: LAT must be 1..4");
    end

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic              hit;
    logic              we;
    logic              rd_ok;
    logic [DATA_W-1:0] ram_q;
    logic              v0;
    logic              oor0;
    logic [DATA_W-1:0] s0;
    logic              out_v;
    logic [DATA_W-1:0] out_d;
    logic [DATA_W-1:0] hold;

    assign hit   = in_range(DADDR, BASE_WORD, AW);
    assign we    = RSTN && DREQ && (DRW == DRW_WRITE) && hit;
    assign rd_ok = DREQ && (DRW == DRW_READ) && hit;

    dmem_ram #(.AW(AW)) u_ram (
        .CLK   (CLK),
        .WE    (we),
        .ADDR  (DADDR[AW-1:0]),
        .WDATA (DWDATA),
        .RDATA (ram_q)
    );

    // Stage 0 is the RAM output register itself; v0/oor0 travel with it.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            v0   <= 1'b0;
            oor0 <= 1'b0;
        end else begin
            v0   <= DREQ && (DRW == DRW_READ);
            oor0 <= !hit;
        end
    end

    assign s0 = oor0 ? '0 : ram_q;

    if (LAT == 1) begin : g_l1
        assign out_v = v0;
        assign out_d = s0;
    end else begin : g_ln
        logic [LAT-2:0]    sv;
        logic [DATA_W-1:0] sd [LAT-1];

        always_ff @(posedge CLK) begin
            if (!RSTN) begin
                sv <= '0;
                for (int i = 0; i < LAT-1; i++)
                    sd[i] <= '0;
            end else begin
                sv[0] <= v0;
                sd[0] <= v0 ? s0 : '0;
                for (int i = 1; i < LAT-1; i++) begin
                    sv[i] <= sv[i-1];
                    sd[i] <= sd[i-1];
                end
            end
        end

        assign out_v = sv[LAT-2];
        assign out_d = sd[LAT-2];
    end

    // DRDATA keeps the last result between valid cycles.
    always_ff @(posedge CLK) begin
        if (!RSTN)
            hold <= '0;
        else if (out_v)
            hold <= out_d;
    end

    assign RVALID = out_v;
    assign DRDATA = out_v ? out_d : hold;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            ERR      <= 1'b0;
            ERR_ADDR <= '0;
            ERR_RW   <= 1'b0;
            RD_CNT   <= '0;
            WR_CNT   <= '0;
        end else begin
            if (DREQ && !hit && !ERR) begin
                ERR      <= 1'b1;
                ERR_ADDR <= DADDR;
                ERR_RW   <= DRW;
            end
            if (rd_ok && RD_CNT != CNT_MAX)
                RD_CNT <= RD_CNT + 1'b1;
            if (we && WR_CNT != CNT_MAX)
                WR_CNT <= WR_CNT + 1'b1;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responder instances (LAT 1/3/2, and CW=4).
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn  [4];
    logic        req   [4];
    logic        drw   [4];
    logic [29:0] addr  [4];
    logic [31:0] wd    [4];
    logic [31:0] rdata [4];
    logic        rvld  [4];
    logic        err   [4];
    logic [29:0] eaddr [4];
    logic        erw   [4];
    logic [15:0] rc    [3];
    logic [15:0] wc    [3];
    logic [3:0]  rc3, wc3;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_responder #(.LAT(1)) u_d0 (
        .CLK(clk), .RSTN(rstn[0]), .DREQ(req[0]), .DRW(drw[0]),
        .DADDR(addr[0]), .DWDATA(wd[0]), .DRDATA(rdata[0]),
        .RVALID(rvld[0]), .ERR(err[0]), .ERR_ADDR(eaddr[0]),
        .ERR_RW(erw[0]), .RD_CNT(rc[0]), .WR_CNT(wc[0])
    );
    dmem_responder #(.LAT(3)) u_d1 (
        .CLK(clk), .RSTN(rstn[1]), .DREQ(req[1]), .DRW(drw[1]),
        .DADDR(addr[1]), .DWDATA(wd[1]), .DRDATA(rdata[1]),
        .RVALID(rvld[1]), .ERR(err[1]), .ERR_ADDR(eaddr[1]),
        .ERR_RW(erw[1]), .RD_CNT(rc[1]), .WR_CNT(wc[1])
    );
    dmem_responder #(.LAT(2)) u_d2 (
        .CLK(clk), .RSTN(rstn[2]), .DREQ(req[2]), .DRW(drw[2]),
        .DADDR(addr[2]), .DWDATA(wd[2]), .DRDATA(rdata[2]),
        .RVALID(rvld[2]), .ERR(err[2]), .ERR_ADDR(eaddr[2]),
        .ERR_RW(erw[2]), .RD_CNT(rc[2]), .WR_CNT(wc[2])
    );
    dmem_responder #(.LAT(1), .CW(4)) u_d3 (
        .CLK(clk), .RSTN(rstn[3]), .DREQ(req[3]), .DRW(drw[3]),
        .DADDR(addr[3]), .DWDATA(wd[3]), .DRDATA(rdata[3]),
        .RVALID(rvld[3]), .ERR(err[3]), .ERR_ADDR(eaddr[3]),
        .ERR_RW(erw[3]), .RD_CNT(rc3), .WR_CNT(wc3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int k, input logic rw,
                      input logic [29:0] a, input logic [31:0] d);
        req[k]  = 1'b1;
        drw[k]  = rw;
        addr[k] = a;
        wd[k]   = d;
        step();
        req[k]  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rstn[k] = 1'b0; req[k] = 1'b0; drw[k] = 1'b0;
            addr[k] = '0;   wd[k]  = '0;
        end
        step();
        step();
        for (int k = 0; k < 4; k++) rstn[k] = 1'b1;

        chk("rst_rdata", rdata[0], 32'h0);
        chk("rst_rvalid", {31'b0, rvld[0]}, 32'h0);
        chk("rst_err", {31'b0, err[0]}, 32'h0);
        chk("rst_rdcnt", {16'b0, rc[0]}, 32'h0);
        chk("rst_wrcnt", {16'b0, wc[0]}, 32'h0);

        // Write then immediate read, LAT=1
        op(0, 1'b1, 30'd5, 32'hDEADBEEF);
        chk("w_no_rvalid", {31'b0, rvld[0]}, 32'h0);
        op(0, 1'b0, 30'd5, 32'h0);
        chk("rw_rvalid", {31'b0, rvld[0]}, 32'h1);
        chk("rw_rdata", rdata[0], 32'hDEADBEEF);
        chk("rw_wrcnt", {16'b0, wc[0]}, 32'h1);
        chk("rw_rdcnt", {16'b0, rc[0]}, 32'h1);
        step();
        chk("idle_rvalid", {31'b0, rvld[0]}, 32'h0);
        chk("hold_rdata", rdata[0], 32'hDEADBEEF);

        // Back-to-back reads, LAT=1
        for (int i = 0; i < 4; i++) op(0, 1'b1, 30'(i), 32'h10 + 32'(i));
        for (int i = 0; i < 4; i++) begin
            req[0] = 1'b1; drw[0] = 1'b0; addr[0] = 30'(i);
            step();
            chk("b2b1_rvalid", {31'b0, rvld[0]}, 32'h1);
            chk("b2b1_rdata", rdata[0], 32'h10 + 32'(i));
        end
        req[0] = 1'b0;

        // Back-to-back reads, LAT=3
        for (int i = 0; i < 4; i++) op(1, 1'b1, 30'(i), 32'h10 + 32'(i));
        for (int c = 0; c < 6; c++) begin
            req[1] = (c < 4); drw[1] = 1'b0; addr[1] = 30'(c);
            step();
            if (c < 2) begin
                chk("b2b3_early", {31'b0, rvld[1]}, 32'h0);
            end else begin
                chk("b2b3_rvalid", {31'b0, rvld[1]}, 32'h1);
                chk("b2b3_rdata", rdata[1], 32'h10 + 32'(c - 2));
            end
        end
        req[1] = 1'b0;

        // In-flight read is not disturbed by a later write, LAT=3
        op(1, 1'b1, 30'd7, 32'hA);
        op(1, 1'b0, 30'd7, 32'h0);
        op(1, 1'b1, 30'd7, 32'hB);
        step();
        chk("inflight_rvalid", {31'b0, rvld[1]}, 32'h1);
        chk("inflight_rdata", rdata[1], 32'hA);
        op(1, 1'b0, 30'd7, 32'h0);
        step();
        step();
        chk("reread_rdata", rdata[1], 32'hB);

        // Out-of-range on a fresh instance, LAT=2
        op(2, 1'b1, 30'h400, 32'h55);
        op(2, 1'b0, 30'h800, 32'h0);
        step();
        chk("oor_rvalid", {31'b0, rvld[2]}, 32'h1);
        chk("oor_rdata", rdata[2], 32'h0);
        chk("oor_err", {31'b0, err[2]}, 32'h1);
        chk("oor_eaddr", {2'b0, eaddr[2]}, 32'h400);
        chk("oor_erw", {31'b0, erw[2]}, 32'h1);
        chk("oor_rdcnt", {16'b0, rc[2]}, 32'h0);
        chk("oor_wrcnt", {16'b0, wc[2]}, 32'h0);

        // Dropped OOR write must not alias onto index 0, LAT=1
        op(0, 1'b1, 30'h400, 32'h55);
        op(0, 1'b0, 30'h0, 32'h0);
        chk("drop_rdata", rdata[0], 32'h10);
        op(0, 1'b0, 30'h800, 32'h0);
        chk("oor1_rvalid", {31'b0, rvld[0]}, 32'h1);
        chk("oor1_rdata", rdata[0], 32'h0);
        chk("oor1_eaddr", {2'b0, eaddr[0]}, 32'h400);

        // Saturating write counter, CW=4
        for (int i = 0; i < 20; i++) op(3, 1'b1, 30'(i), 32'(i));
        chk("sat_wrcnt", {28'b0, wc3}, 32'hF);
        chk("sat_rdcnt", {28'b0, rc3}, 32'h0);

        // Reset discards in-flight read, RAM survives, LAT=2
        op(2, 1'b1, 30'd9, 32'h1234);
        op(2, 1'b0, 30'd9, 32'h0);
        rstn[2] = 1'b0;
        step();
        chk("rst_if_rvalid", {31'b0, rvld[2]}, 32'h0);
        chk("rst_if_rdata", rdata[2], 32'h0);
        chk("rst_if_err", {31'b0, err[2]}, 32'h0);
        chk("rst_if_cnt", {rc[2], wc[2]}, 32'h0);
        rstn[2] = 1'b1;
        step();
        chk("rst_if_rvalid2", {31'b0, rvld[2]}, 32'h0);
        op(2, 1'b0, 30'd9, 32'h0);
        step();
        chk("post_rst_rvalid", {31'b0, rvld[2]}, 32'h1);
        chk("post_rst_rdata", rdata[2], 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
